slavefifo_pkt_writer: RTL and testbench

//  Parametrised FX3 slave-FIFO write-side packet generator: next generation of the partial-mode writer.

---
 rtl/slavefifo_pkt_writer.sv | 152 +++++++++++++++
 tb/tb_slavefifo_pkt_writer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/slavefifo_pkt_writer.sv
// FX3 slave-FIFO write-side packet generator: streams an incrementing pattern,
// closes short packets with PKTEND, or issues zero-length packets.
module slavefifo_pkt_writer #(
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 12,
    parameter int WR_DELAY   = 1,
    parameter int GAP_CYCLES = 8
) (
    input  logic              clk_100,
    input  logic              reset_,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic              flaga_d,
    input  logic              flagb_d,
    output logic              slwr_,
    output logic              pktend_,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              pkt_done,
    output logic [15:0]       pkt_count
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FLAGB,
        WRITE,
        ZLP,
        DELAY,
        GAP
    } state_t;

    localparam logic [1:0]       MODE_SHORT = 2'b01;
    localparam logic [1:0]       MODE_ZLP   = 2'b10;
    localparam int               CNT_W      = 16;
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(WR_DELAY - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    state_t            state_q;
    logic [1:0]        mode_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  word_cnt_q;
    logic [DATA_W-1:0] data_q;
    logic [15:0]       pkt_cnt_q;
    logic [CNT_W-1:0]  tmr_q;

    logic wr_accept;
    logic last_word;
    logic pkt_end;

    // The FX3 samples the strobe on the same edge as the flag, so the write
    // decision must follow flagb_d/enable combinationally.
    always_comb begin
        wr_accept = (state_q == WRITE) && flagb_d && enable;
        last_word = wr_accept && (mode_q == MODE_SHORT) &&
                    (word_cnt_q == (len_q - LEN_W'(1)));
        pkt_end   = last_word || (state_q == ZLP);
    end

    assign slwr_     = ~wr_accept;
    assign pktend_   = ~pkt_end;
    assign pkt_done  = pkt_end;
    assign busy      = (state_q != IDLE);
    assign data_out  = data_q;
    assign pkt_count = pkt_cnt_q;

    always_ff @(posedge clk_100) begin
        if (!reset_) begin
            state_q    <= IDLE;
            mode_q     <= 2'b00;
            len_q      <= '0;
            word_cnt_q <= '0;
            data_q     <= '0;
            pkt_cnt_q  <= '0;
            tmr_q      <= '0;
        end else begin
            if (!enable) begin
                data_q <= '0;
            end else if (wr_accept) begin
                data_q <= data_q + DATA_W'(1);
            end

            if (pkt_end) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end

            case (state_q)
                IDLE: begin
                    tmr_q <= '0;
                    if (enable && flaga_d) begin
                        mode_q <= mode;
                        len_q  <= pkt_len;
                        if ((mode == MODE_ZLP) || ((mode == MODE_SHORT) && (pkt_len == '0))) begin
                            state_q <= ZLP;
                        end else begin
                            state_q <= WAIT_FLAGB;
                        end
                    end
                end
                WAIT_FLAGB: begin
                    tmr_q <= '0;
                    if (!enable) begin
                        word_cnt_q <= '0;
                        state_q    <= IDLE;
                    end else if (flagb_d) begin
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    tmr_q <= '0;
                    if (!enable) begin
                        word_cnt_q <= '0;
                        state_q    <= DELAY;
                    end else if (!flagb_d) begin
                        // word_cnt_q is held so a stalled short packet resumes where it stopped
                        state_q <= DELAY;
                    end else if (last_word) begin
                        word_cnt_q <= '0;
                        state_q    <= DELAY;
                    end else begin
                        word_cnt_q <= word_cnt_q + LEN_W'(1);
                    end
                end
                ZLP: begin
                    tmr_q   <= '0;
                    state_q <= DELAY;
                end
                DELAY: begin
                    if (tmr_q == DELAY_LAST) begin
                        tmr_q   <= '0;
                        state_q <= GAP;
                    end else begin
                        tmr_q <= tmr_q + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (tmr_q == GAP_LAST) begin
                        tmr_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        tmr_q <= tmr_q + CNT_W'(1);
                    end
                end
                default: begin
                    tmr_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slavefifo_pkt_writer.sv
// Directed bench for slavefifo_pkt_writer: short, stall, ZLP, stream, abort
// and reset scenarios with hand-computed expectations.
module tb_slavefifo_pkt_writer;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 12;
    localparam int BUDGET = 200;

    logic              clk_100 = 1'b0;
    logic              reset_;
    logic              enable;
    logic [1:0]        mode;
    logic [LEN_W-1:0]  pkt_len;
    logic              flaga_d;
    logic              flagb_d;
    logic              slwr_;
    logic              pktend_;
    logic [DATA_W-1:0] data_out;
    logic              busy;
    logic              pkt_done;
    logic [15:0]       pkt_count;

    int n_checks = 0;
    int n_errors = 0;

    slavefifo_pkt_writer #(
        .DATA_W    (DATA_W),
        .LEN_W     (LEN_W),
        .WR_DELAY  (1),
        .GAP_CYCLES(8)
    ) dut (
        .clk_100  (clk_100),
        .reset_   (reset_),
        .enable   (enable),
        .mode     (mode),
        .pkt_len  (pkt_len),
        .flaga_d  (flaga_d),
        .flagb_d  (flagb_d),
        .slwr_    (slwr_),
        .pktend_  (pktend_),
        .data_out (data_out),
        .busy     (busy),
        .pkt_done (pkt_done),
        .pkt_count(pkt_count)
    );

    always #5 clk_100 = ~clk_100;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic cyc();
        @(posedge clk_100);
        #1;
    endtask

    // Advance until a write strobe is seen; n = cycles advanced.
    task automatic wait_wr(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (slwr_ && n < BUDGET);
        check("wr_timeout", 32'(n >= BUDGET), 32'd0);
    endtask

    task automatic wait_pe(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (pktend_ && n < BUDGET);
        check("pe_timeout", 32'(n >= BUDGET), 32'd0);
    endtask

    initial begin
        int n;
        int pe_seen;

        reset_  = 1'b0;
        enable  = 1'b0;
        mode    = 2'b00;
        pkt_len = '0;
        flaga_d = 1'b0;
        flagb_d = 1'b0;
        repeat (3) cyc();
        check("init_busy", 32'(busy), 32'd0);
        check("init_slwr", 32'(slwr_), 32'd1);

        // Short packet of 16 words, then the start of the next one
        reset_  = 1'b1;
        enable  = 1'b1;
        mode    = 2'b01;
        pkt_len = 12'd16;
        flaga_d = 1'b1;
        flagb_d = 1'b1;
        for (int k = 0; k < 16; k++) begin
            wait_wr(n);
            if (k > 0) check("short_consec", 32'(n), 32'd1);
            check("short_data", data_out, 32'(k));
            check("short_pktend", 32'(pktend_), (k == 15) ? 32'd0 : 32'd1);
        end
        check("short_done", 32'(pkt_done), 32'd1);
        for (int k = 0; k < 9; k++) begin
            cyc();
            check("short_gap", {29'd0, slwr_, pktend_, busy}, 32'd7);
        end
        cyc();
        check("short_idle", 32'(busy), 32'd0);
        wait_wr(n);
        check("short_next_data", data_out, 32'd16);
        check("short_pkt_count", 32'(pkt_count), 32'd1);

        // Reset held for 3 cycles while writing
        reset_ = 1'b0;
        repeat (3) cyc();
        check("rst_slwr", 32'(slwr_), 32'd1);
        check("rst_pktend", 32'(pktend_), 32'd1);
        check("rst_data", data_out, 32'd0);
        check("rst_count", 32'(pkt_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Stall after 10 words, resume for the remaining 6
        reset_ = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_wr(n);
            check("stall_data", data_out, 32'(k));
        end
        cyc();
        flagb_d = 1'b0;
        #1;
        check("stall_stop", 32'(slwr_), 32'd1);
        check("stall_hold_data", data_out, 32'd10);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (!slwr_) n++;
        end
        check("stall_no_writes", 32'(n), 32'd0);
        flagb_d = 1'b1;
        for (int k = 10; k < 16; k++) begin
            wait_wr(n);
            check("resume_data", data_out, 32'(k));
            check("resume_pktend", 32'(pktend_), (k == 15) ? 32'd0 : 32'd1);
        end
        mode = 2'b10;
        cyc();
        check("stall_pkt_count", 32'(pkt_count), 32'd1);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (!slwr_) n++;
        end
        check("resume_no_extra", 32'(n), 32'd0);

        // ZLP via mode 10, then via short mode with length 0
        wait_pe(n);
        check("zlp_slwr", 32'(slwr_), 32'd1);
        check("zlp_data", data_out, 32'd16);
        check("zlp_done", 32'(pkt_done), 32'd1);
        mode    = 2'b01;
        pkt_len = 12'd0;
        cyc();
        check("zlp_one_cycle", 32'(pktend_), 32'd1);
        check("zlp_count", 32'(pkt_count), 32'd2);
        check("zlp_data_after", data_out, 32'd16);
        wait_pe(n);
        check("zlp0_slwr", 32'(slwr_), 32'd1);
        cyc();
        check("zlp0_count", 32'(pkt_count), 32'd3);

        // Stream 100 words, then abort with enable low
        enable  = 1'b0;
        mode    = 2'b00;
        pkt_len = 12'd16;
        n = 0;
        while (busy && n < BUDGET) begin
            cyc();
            n++;
        end
        check("stream_idle_timeout", 32'(n >= BUDGET), 32'd0);
        enable  = 1'b1;
        pe_seen = 0;
        for (int k = 0; k < 100; k++) begin
            wait_wr(n);
            if (k > 0) check("stream_consec", 32'(n), 32'd1);
            check("stream_data", data_out, 32'(k));
            if (!pktend_) pe_seen++;
        end
        check("stream_no_pktend", 32'(pe_seen), 32'd0);
        cyc();
        enable = 1'b0;
        #1;
        check("abort_slwr", 32'(slwr_), 32'd1);
        cyc();
        check("abort_data", data_out, 32'd0);
        n = 0;
        while (busy && n < 50) begin
            n++;
            cyc();
        end
        check("abort_busy_cycles", 32'(n), 32'd9);

        // Abort cleared the word counter: a 3-word packet ends on its third word
        mode    = 2'b01;
        pkt_len = 12'd3;
        enable  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_wr(n);
            check("post_abort_data", data_out, 32'(k));
            check("post_abort_pktend", 32'(pktend_), (k == 2) ? 32'd0 : 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
